// File: rtl/spcpu_alu_decode_unit_pkg.sv
// ============================================================================
//  Module : pkg_spcpu_alu_dec
//  Brief  : Shared types for the spcpu ALU/decode front end: instruction
//           groups, ALU operations, group-1 opcodes and flag bit positions.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pkg_spcpu_alu_dec;

    typedef enum logic [2:0] {
        GRP_UNKNOWN = 3'd0,
        GRP_1       = 3'd1,
        GRP_2       = 3'd2,
        GRP_3       = 3'd3,
        GRP_4       = 3'd4,
        GRP_5       = 3'd5
    } instr_group_t;

    typedef enum logic [3:0] {
        ALU_ADD8  = 4'd0,
        ALU_ADC8  = 4'd1,
        ALU_SUB8  = 4'd2,
        ALU_SBC8  = 4'd3,
        ALU_CMP8  = 4'd4,
        ALU_AND8  = 4'd5,
        ALU_ORR8  = 4'd6,
        ALU_XOR8  = 4'd7,
        ALU_LSL8  = 4'd8,
        ALU_LSR8  = 4'd9,
        ALU_ASR8  = 4'd10,
        ALU_ROLC8 = 4'd11,
        ALU_RORC8 = 4'd12,
        ALU_ADD16 = 4'd13,
        ALU_SUB16 = 4'd14,
        ALU_CPYB  = 4'd15
    } alu_oper_t;

    typedef enum logic [2:0] {
        G1_ADDI = 3'd0,
        G1_ADCI = 3'd1,
        G1_SUBI = 3'd2,
        G1_SBCI = 3'd3,
        G1_CMPI = 3'd4,
        G1_ANDI = 3'd5,
        G1_ORRI = 3'd6,
        G1_CPYI = 3'd7
    } g1_opcode_t;

    localparam int unsigned C_FLAG_Z = 3;
    localparam int unsigned C_FLAG_C = 2;
    localparam int unsigned C_FLAG_V = 1;
    localparam int unsigned C_FLAG_N = 0;

    // Group-1 opcodes 0..6 share the ALU encoding; only cpyi needs remapping.
    function automatic alu_oper_t g1_to_alu(input g1_opcode_t op);
        return (op == G1_CPYI) ? ALU_CPYB : alu_oper_t'({1'b0, op});
    endfunction

endpackage

`default_nettype wire

// File: rtl/spcpu_alu_decode_unit_core.sv
// ============================================================================
//  Module : spcpu_alu_core
//  Brief  : Combinational 8/16-bit ALU with {Z,C,V,N} flag generation.
//           Shifter ops 8..12 are present only with SPCPU_ALU_SHIFT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spcpu_alu_core
    import pkg_spcpu_alu_dec::*;
(
    input  alu_oper_t   oper_i,
    input  logic [7:0]  a_hi_i,
    input  logic [7:0]  a_lo_i,
    input  logic [7:0]  b_hi_i,
    input  logic [7:0]  b_lo_i,
    input  logic [3:0]  flags_i,
    output logic [7:0]  out_hi_o,
    output logic [7:0]  out_lo_o,
    output logic [3:0]  flags_o
);

    logic        w_sub;
    logic        w_cin;
    logic [7:0]  w_b8;
    logic [15:0] w_b16;
    logic [8:0]  w_sum8;
    logic [16:0] w_sum16;
    logic        w_v8;
    logic        w_v16;

    // Subtraction is a + ~b + cin, so C=1 means "no borrow".
    always_comb begin
        w_sub = (oper_i == ALU_SUB8) || (oper_i == ALU_SBC8) ||
                (oper_i == ALU_CMP8) || (oper_i == ALU_SUB16);
        case (oper_i)
            ALU_ADC8, ALU_SBC8:           w_cin = flags_i[C_FLAG_C];
            ALU_SUB8, ALU_CMP8, ALU_SUB16: w_cin = 1'b1;
            default:                      w_cin = 1'b0;
        endcase
        w_b8    = w_sub ? ~b_lo_i : b_lo_i;
        w_b16   = w_sub ? ~{b_hi_i, b_lo_i} : {b_hi_i, b_lo_i};
        w_sum8  = {1'b0, a_lo_i} + {1'b0, w_b8} + {8'd0, w_cin};
        w_sum16 = {1'b0, a_hi_i, a_lo_i} + {1'b0, w_b16} + {16'd0, w_cin};
        w_v8    = (a_lo_i[7] == w_b8[7]) && (w_sum8[7] != a_lo_i[7]);
        w_v16   = (a_hi_i[7] == w_b16[15]) && (w_sum16[15] != a_hi_i[7]);
    end

    logic [7:0]  w_r8;
    logic        w_zn8;
    logic        w_wide;
    logic [15:0] w_r16;

    always_comb begin
        w_r8    = a_lo_i;
        w_zn8   = 1'b0;
        w_wide  = 1'b0;
        w_r16   = {a_hi_i, a_lo_i};
        flags_o = flags_i;
        case (oper_i)
            ALU_ADD8, ALU_ADC8, ALU_SUB8, ALU_SBC8: begin
                w_r8              = w_sum8[7:0];
                w_zn8             = 1'b1;
                flags_o[C_FLAG_C] = w_sum8[8];
                flags_o[C_FLAG_V] = w_v8;
            end
            ALU_CMP8: begin
                flags_o[C_FLAG_Z] = (w_sum8[7:0] == 8'd0);
                flags_o[C_FLAG_N] = w_sum8[7];
                flags_o[C_FLAG_C] = w_sum8[8];
                flags_o[C_FLAG_V] = w_v8;
            end
            ALU_AND8: begin w_r8 = a_lo_i & b_lo_i; w_zn8 = 1'b1; end
            ALU_ORR8: begin w_r8 = a_lo_i | b_lo_i; w_zn8 = 1'b1; end
            ALU_XOR8: begin w_r8 = a_lo_i ^ b_lo_i; w_zn8 = 1'b1; end
`ifdef SPCPU_ALU_SHIFT_EN
            ALU_LSL8: begin
                w_r8 = {a_lo_i[6:0], 1'b0}; w_zn8 = 1'b1; flags_o[C_FLAG_C] = a_lo_i[7];
            end
            ALU_LSR8: begin
                w_r8 = {1'b0, a_lo_i[7:1]}; w_zn8 = 1'b1; flags_o[C_FLAG_C] = a_lo_i[0];
            end
            ALU_ASR8: begin
                w_r8 = {a_lo_i[7], a_lo_i[7:1]}; w_zn8 = 1'b1; flags_o[C_FLAG_C] = a_lo_i[0];
            end
            ALU_ROLC8: begin
                w_r8 = {a_lo_i[6:0], flags_i[C_FLAG_C]}; w_zn8 = 1'b1;
                flags_o[C_FLAG_C] = a_lo_i[7];
            end
            ALU_RORC8: begin
                w_r8 = {flags_i[C_FLAG_C], a_lo_i[7:1]}; w_zn8 = 1'b1;
                flags_o[C_FLAG_C] = a_lo_i[0];
            end
`endif
            ALU_ADD16, ALU_SUB16: begin
                w_wide            = 1'b1;
                w_r16             = w_sum16[15:0];
                flags_o[C_FLAG_Z] = (w_sum16[15:0] == 16'd0);
                flags_o[C_FLAG_N] = w_sum16[15];
                flags_o[C_FLAG_C] = w_sum16[16];
                flags_o[C_FLAG_V] = w_v16;
            end
            // Copy moves the full 16-bit B operand.
            ALU_CPYB: begin
                w_wide = 1'b1;
                w_r16  = {b_hi_i, b_lo_i};
            end
            default: ;
        endcase
        if (w_zn8) begin
            flags_o[C_FLAG_Z] = (w_r8 == 8'd0);
            flags_o[C_FLAG_N] = w_r8[7];
        end
        {out_hi_o, out_lo_o} = w_wide ? w_r16 : {a_hi_i, w_r8};
    end

endmodule

`default_nettype wire

// File: rtl/spcpu_alu_decode_unit.sv
// ============================================================================
//  Module : spcpu_alu_decode_unit
//  Brief  : Registered execute front end: group decode, group-1 field decode,
//           operand mux and one ALU op. Shifter enabled by SPCPU_ALU_SHIFT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spcpu_alu_decode_unit
    import pkg_spcpu_alu_dec::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] instr_hi,
    input  logic [3:0]  ext_oper,
    input  logic [7:0]  a_in_hi,
    input  logic [7:0]  a_in_lo,
    input  logic [7:0]  b_in_hi,
    input  logic [7:0]  b_in_lo,
    input  logic [3:0]  flags_in,
    output logic        out_valid,
    output logic [2:0]  grp_out,
    output logic [2:0]  g1_opcode,
    output logic [3:0]  g1_ra_index,
    output logic [7:0]  g1_imm,
    output logic [7:0]  alu_out_hi,
    output logic [7:0]  alu_out_lo,
    output logic [3:0]  flags_out,
    output logic        bad_instr
);

    instr_group_t grp_d;
    logic         is_g1;
    g1_opcode_t   g1_op_d;
    logic [3:0]   ra_d;
    logic [7:0]   imm_d;
    alu_oper_t    w_oper;
    logic [7:0]   w_b_hi;
    logic [7:0]   w_b_lo;
    logic [7:0]   w_core_hi;
    logic [7:0]   w_core_lo;
    logic [3:0]   w_core_flags;
    logic [15:0]  res_d;
    logic [3:0]   flags_d;
    logic         bad_d;

    // Group is the count of leading ones in [15:11], plus one.
    always_comb begin
        if (!instr_hi[15])      grp_d = GRP_1;
        else if (!instr_hi[14]) grp_d = GRP_2;
        else if (!instr_hi[13]) grp_d = GRP_3;
        else if (!instr_hi[12]) grp_d = GRP_4;
        else if (!instr_hi[11]) grp_d = GRP_5;
        else                    grp_d = GRP_UNKNOWN;
    end

    always_comb begin
        is_g1   = (grp_d == GRP_1);
        g1_op_d = is_g1 ? g1_opcode_t'(instr_hi[14:12]) : G1_ADDI;
        ra_d    = is_g1 ? instr_hi[11:8] : 4'd0;
        imm_d   = is_g1 ? instr_hi[7:0]  : 8'd0;
        w_oper  = is_g1 ? g1_to_alu(g1_op_d) : alu_oper_t'(ext_oper);
        w_b_hi  = is_g1 ? 8'h00 : b_in_hi;
        w_b_lo  = is_g1 ? imm_d : b_in_lo;
    end

    spcpu_alu_core u_core (
        .oper_i   (w_oper),
        .a_hi_i   (a_in_hi),
        .a_lo_i   (a_in_lo),
        .b_hi_i   (w_b_hi),
        .b_lo_i   (w_b_lo),
        .flags_i  (flags_in),
        .out_hi_o (w_core_hi),
        .out_lo_o (w_core_lo),
        .flags_o  (w_core_flags)
    );

    always_comb begin
        bad_d   = (grp_d == GRP_UNKNOWN);
        res_d   = bad_d ? {a_in_hi, a_in_lo} : {w_core_hi, w_core_lo};
        flags_d = bad_d ? flags_in : w_core_flags;
    end

    logic         out_valid_q;
    instr_group_t grp_q;
    g1_opcode_t   g1_op_q;
    logic [3:0]   ra_q;
    logic [7:0]   imm_q;
    logic [15:0]  res_q;
    logic [3:0]   flags_q;
    logic         bad_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            grp_q       <= GRP_UNKNOWN;
            g1_op_q     <= G1_ADDI;
            ra_q        <= 4'd0;
            imm_q       <= 8'd0;
            res_q       <= 16'd0;
            flags_q     <= 4'd0;
            bad_q       <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                grp_q   <= grp_d;
                g1_op_q <= g1_op_d;
                ra_q    <= ra_d;
                imm_q   <= imm_d;
                res_q   <= res_d;
                flags_q <= flags_d;
                bad_q   <= bad_d;
            end
        end
    end

    assign out_valid                = out_valid_q;
    assign grp_out                  = grp_q;
    assign g1_opcode                = g1_op_q;
    assign g1_ra_index              = ra_q;
    assign g1_imm                   = imm_q;
    assign {alu_out_hi, alu_out_lo} = res_q;
    assign flags_out                = flags_q;
    assign bad_instr                = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_spcpu_alu_decode_unit.sv
// ============================================================================
//  Module : tb_spcpu_alu_decode_unit
//  Brief  : Self-checking bench for spcpu_alu_decode_unit against an
//           arithmetic reference model (honours SPCPU_ALU_SHIFT_EN).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spcpu_alu_decode_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] instr_hi = '0;
    logic [3:0]  ext_oper = '0;
    logic [7:0]  a_in_hi = '0, a_in_lo = '0, b_in_hi = '0, b_in_lo = '0;
    logic [3:0]  flags_in = '0;
    logic        out_valid, bad_instr;
    logic [2:0]  grp_out, g1_opcode;
    logic [3:0]  g1_ra_index, flags_out;
    logic [7:0]  g1_imm, alu_out_hi, alu_out_lo;

    int errors = 0;
    int checks = 0;
    logic [39:0] prev = '0;

    always #5 clk = ~clk;

    spcpu_alu_decode_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr_hi(instr_hi),
        .ext_oper(ext_oper), .a_in_hi(a_in_hi), .a_in_lo(a_in_lo),
        .b_in_hi(b_in_hi), .b_in_lo(b_in_lo), .flags_in(flags_in),
        .out_valid(out_valid), .grp_out(grp_out), .g1_opcode(g1_opcode),
        .g1_ra_index(g1_ra_index), .g1_imm(g1_imm), .alu_out_hi(alu_out_hi),
        .alu_out_lo(alu_out_lo), .flags_out(flags_out), .bad_instr(bad_instr)
    );

    wire [39:0] obs = {out_valid, grp_out, g1_opcode, g1_ra_index, g1_imm,
                       alu_out_hi, alu_out_lo, flags_out, bad_instr};

    // Expected {valid,grp,opcode,ra,imm,hi,lo,flags,bad} for one captured cycle.
    function automatic logic [39:0] model(input logic [15:0] ins, input logic [3:0] eop,
                                          input logic [7:0] ahi, input logic [7:0] alo,
                                          input logic [7:0] bhi, input logic [7:0] blo,
                                          input logic [3:0] fin);
        int k, op, a, b, r, sa, sb, sr, cin, A, B, sA, sB;
        logic z, c, v, n, cn;
        logic [15:0] res;
        logic [7:0] bh, bl, imm;
        logic [2:0] gop;
        logic [3:0] ra;
        k = 0;
        while (k < 5 && ins[15-k]) k++;
        if (k == 5) return {1'b1, 3'd0, 3'd0, 4'd0, 8'd0, ahi, alo, fin, 1'b1};
        z = fin[3]; c = fin[2]; v = fin[1]; n = fin[0];
        gop = '0; ra = '0; imm = '0; bh = bhi; bl = blo; op = int'(eop);
        if (k == 0) begin
            gop = ins[14:12]; ra = ins[11:8]; imm = ins[7:0];
            bh = 8'h00; bl = imm; op = (gop == 3'd7) ? 15 : int'(gop);
        end
        a = int'(alo); b = int'(bl);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = {ahi, alo};
        case (op)
            0, 1: begin
                cin = (op == 1 && c) ? 1 : 0;
                r = a + b + cin; sr = sa + sb + cin;
                c = (r > 255); v = (sr < -128 || sr > 127);
                res[7:0] = r[7:0]; z = (r[7:0] == 8'd0); n = r[7];
            end
            2, 3, 4: begin
                cin = (op == 3 && !c) ? 1 : 0;
                r = a - b - cin; sr = sa - sb - cin;
                c = (r >= 0); v = (sr < -128 || sr > 127);
                z = (r[7:0] == 8'd0); n = r[7];
                if (op != 4) res[7:0] = r[7:0];
            end
            5, 6, 7: begin
                r = (op == 5) ? (a & b) : (op == 6) ? (a | b) : (a ^ b);
                res[7:0] = r[7:0]; z = (r == 0); n = r[7];
            end
`ifdef SPCPU_ALU_SHIFT_EN
            8, 9, 10, 11, 12: begin
                case (op)
                    8:       begin r = (a * 2) % 256;                cn = (a >= 128); end
                    9:       begin r = a / 2;                         cn = (a % 2 == 1); end
                    10:      begin r = a / 2 + ((a >= 128) ? 128 : 0); cn = (a % 2 == 1); end
                    11:      begin r = (a * 2) % 256 + (c ? 1 : 0);  cn = (a >= 128); end
                    default: begin r = a / 2 + (c ? 128 : 0);        cn = (a % 2 == 1); end
                endcase
                c = cn; res[7:0] = r[7:0]; z = (r == 0); n = r[7];
            end
`endif
            13, 14: begin
                A = int'({ahi, alo}); B = int'({bh, bl});
                sA = (A >= 32768) ? A - 65536 : A;
                sB = (B >= 32768) ? B - 65536 : B;
                if (op == 13) begin r = A + B; sr = sA + sB; c = (r > 65535); end
                else          begin r = A - B; sr = sA - sB; c = (r >= 0); end
                v = (sr < -32768 || sr > 32767);
                res = r[15:0]; z = (res == 16'd0); n = res[15];
            end
            15: res = {bh, bl};
            default: ;
        endcase
        return {1'b1, 3'(k + 1), gop, ra, imm, res, {z, c, v, n}, 1'b0};
    endfunction

    task automatic drive(input logic v, input logic [15:0] ins, input logic [3:0] eop,
                         input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        in_valid = v; instr_hi = ins; ext_oper = eop;
        {a_in_hi, a_in_lo} = a; {b_in_hi, b_in_lo} = b; flags_in = f;
    endtask

    task automatic test_reset;
        logic [39:0] exp;
        reset = 1'b1;
        drive(1'b0, 16'h0000, 4'd0, 16'h0000, 16'h0000, 4'h0);
        #2;
        checks++;
        if (obs !== 40'd0) begin
            errors++; $display("FAIL reset_initial: got %h required %h", obs, 40'd0);
        end
        @(negedge clk); reset = 1'b0;
        // Load a real result, then hit reset between clock edges.
        drive(1'b1, 16'h0305, 4'd0, 16'h12FE, 16'hFFFF, 4'hF);
        exp = model(instr_hi, ext_oper, a_in_hi, a_in_lo, b_in_hi, b_in_lo, flags_in);
        @(posedge clk); #1;
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_preload: got %h required %h", obs, exp);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 40'd0) begin
            errors++; $display("FAIL reset_async: got %h required %h", obs, 40'd0);
        end
        @(negedge clk); reset = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 40'd0) begin
            errors++; $display("FAIL reset_hold: got %h required %h", obs, 40'd0);
        end
        prev = '0;
    endtask

    task automatic test_directed;
        logic [15:0] ins [7] = '{16'h0305, 16'h2101, 16'h4180, 16'h8000, 16'hF800, 16'hF800, 16'hC000};
        logic [3:0]  eop [7] = '{4'd0, 4'd0, 4'd0, 4'd13, 4'd0, 4'd0, 4'd8};
        logic [15:0] av  [7] = '{16'h00FE, 16'h0001, 16'h0000, 16'h00FF, 16'h1234, 16'h5555, 16'h0081};
        logic [15:0] bv  [7] = '{16'hABCD, 16'h1111, 16'h2222, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
        logic [3:0]  fv  [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h3, 4'h0};
        logic        vv  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [39:0] exp [7];
        exp[0] = {1'b1, 3'd1, 3'd0, 4'd3, 8'h05, 8'h00, 8'h03, 4'b0100, 1'b0};
        exp[1] = {1'b1, 3'd1, 3'd2, 4'd1, 8'h01, 8'h00, 8'h00, 4'b1100, 1'b0};
        // 0 - (-128) is a signed overflow, so V is set alongside N.
        exp[2] = {1'b1, 3'd1, 3'd4, 4'd1, 8'h80, 8'h00, 8'h00, 4'b0011, 1'b0};
        exp[3] = {1'b1, 3'd2, 3'd0, 4'd0, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0};
        exp[4] = {1'b1, 3'd0, 3'd0, 4'd0, 8'h00, 8'h12, 8'h34, 4'hA, 1'b1};
        exp[5] = {1'b0, 3'd0, 3'd0, 4'd0, 8'h00, 8'h12, 8'h34, 4'hA, 1'b1};
`ifdef SPCPU_ALU_SHIFT_EN
        exp[6] = {1'b1, 3'd3, 3'd0, 4'd0, 8'h00, 8'h00, 8'h02, 4'b0100, 1'b0};
`else
        exp[6] = {1'b1, 3'd3, 3'd0, 4'd0, 8'h00, 8'h00, 8'h81, 4'b0000, 1'b0};
`endif
        for (int i = 0; i < 7; i++) begin
            drive(vv[i], ins[i], eop[i], av[i], bv[i], fv[i]);
            @(posedge clk); #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL directed_%0d instr=%h: got %h required %h", i, ins[i], obs, exp[i]);
            end
            prev = exp[i];
        end
    endtask

    task automatic test_random;
        logic [39:0] exp;
        logic [15:0] ins;
        for (int i = 0; i < 400; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ins[15] = 1'b1;
            drive(($urandom_range(0, 3) != 0), ins, 4'($urandom), 16'($urandom),
                  16'($urandom), 4'($urandom));
            exp = in_valid ? model(instr_hi, ext_oper, a_in_hi, a_in_lo, b_in_hi, b_in_lo, flags_in)
                           : {1'b0, prev[38:0]};
            @(posedge clk); #1;
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL random_%0d instr=%h op=%0d: got %h required %h",
                                   i, ins, ext_oper, obs, exp);
            end
            prev = exp;
        end
    endtask

    task automatic test_back_to_back;
        logic [39:0] exp;
        for (int op = 0; op < 16; op++) begin
            drive(1'b1, 16'hA000, 4'(op), 16'h80FF, 16'h7F01, 4'($urandom));
            exp = model(instr_hi, ext_oper, a_in_hi, a_in_lo, b_in_hi, b_in_lo, flags_in);
            @(posedge clk); #1;
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL b2b_op%0d: got %h required %h", op, obs, exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
